// File: rtl/canvas_painter.sv
// Brush-stroke painter for the 28x28 drawing canvas: mouse strokes, sequential clear,
// and a registered single-cell read port for the inference engine.
module canvas_painter #(
    parameter int unsigned ORIGIN_X   = 199,
    parameter int unsigned ORIGIN_Y   = 43,
    parameter int unsigned CELL_PX    = 14,
    parameter logic [15:0] CENTER_INC = 16'h0400,
    parameter logic [15:0] EDGE_INC   = 16'h0200,
    parameter logic [15:0] CORNER_INC = 16'h0080,
    parameter logic [15:0] MAX_VAL    = 16'h07FF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  CursorX,
    input  logic [9:0]  CursorY,
    input  logic        Button,
    input  logic        Clear,
    input  logic [9:0]  rd_addr,
    output logic [15:0] canvas [0:27][0:27],
    output logic [15:0] rd_data,
    output logic        busy
);

    localparam int unsigned GridPx = 28 * CELL_PX;

    typedef enum logic [1:0] {StIdle, StPaint, StClear} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  cx_q, cx_d, cy_q, cy_d;
    logic        frame_q;
    logic        tick;

    // Cursor hit test and cell coordinates
    logic        in_hit;
    logic [9:0]  off_x, off_y;
    logic [4:0]  hit_cx, hit_cy;

    always_comb begin
        in_hit = ({1'b0, CursorX} >= 11'(ORIGIN_X)) && ({1'b0, CursorX} < 11'(ORIGIN_X + GridPx))
              && ({1'b0, CursorY} >= 11'(ORIGIN_Y)) && ({1'b0, CursorY} < 11'(ORIGIN_Y + GridPx));
        off_x  = CursorX - 10'(ORIGIN_X);
        off_y  = CursorY - 10'(ORIGIN_Y);
        hit_cx = 5'(off_x / 10'(CELL_PX));
        hit_cy = 5'(off_y / 10'(CELL_PX));
    end

    assign tick = frame_clk & ~frame_q;
    assign busy = (state_q != StIdle);

    // Paint step decode: row r / column c of the 3x3 stamp, 0 meaning offset -1
    logic [1:0]  r, c;
    logic [4:0]  tx, ty, tx_rd, ty_rd;
    logic        tx_ok, ty_ok, wr_en;
    logic [15:0] inc, cur, new_val;
    logic [16:0] sum;

    always_comb begin
        r = 2'd0;
        c = 2'd0;
        unique case (cnt_q)
            5'd0: begin r = 2'd0; c = 2'd0; end
            5'd1: begin r = 2'd0; c = 2'd1; end
            5'd2: begin r = 2'd0; c = 2'd2; end
            5'd3: begin r = 2'd1; c = 2'd0; end
            5'd4: begin r = 2'd1; c = 2'd1; end
            5'd5: begin r = 2'd1; c = 2'd2; end
            5'd6: begin r = 2'd2; c = 2'd0; end
            5'd7: begin r = 2'd2; c = 2'd1; end
            5'd8: begin r = 2'd2; c = 2'd2; end
            default: begin r = 2'd1; c = 2'd1; end
        endcase

        tx    = cx_q + ((c == 2'd0) ? 5'd31 : (c == 2'd2) ? 5'd1 : 5'd0);
        ty    = cy_q + ((r == 2'd0) ? 5'd31 : (r == 2'd2) ? 5'd1 : 5'd0);
        tx_ok = !((c == 2'd0) && (cx_q == 5'd0)) && !((c == 2'd2) && (cx_q == 5'd27));
        ty_ok = !((r == 2'd0) && (cy_q == 5'd0)) && !((r == 2'd2) && (cy_q == 5'd27));
        tx_rd = tx_ok ? tx : 5'd0;
        ty_rd = ty_ok ? ty : 5'd0;

        if ((r == 2'd1) && (c == 2'd1))      inc = CENTER_INC;
        else if ((r == 2'd1) ^ (c == 2'd1))  inc = EDGE_INC;
        else                                 inc = CORNER_INC;

        cur     = canvas[tx_rd][ty_rd];
        sum     = {1'b0, cur} + {1'b0, inc};
        new_val = (sum > {1'b0, MAX_VAL}) ? MAX_VAL : sum[15:0];
        // An abort in the same cycle suppresses that step's write
        wr_en   = (state_q == StPaint) && !Clear && tx_ok && ty_ok;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        unique case (state_q)
            StIdle: begin
                if (Clear) begin
                    state_d = StClear;
                    cnt_d   = 5'd0;
                end else if (tick && Button && in_hit) begin
                    state_d = StPaint;
                    cnt_d   = 5'd0;
                    cx_d    = hit_cx;
                    cy_d    = hit_cy;
                end
            end
            StPaint: begin
                if (Clear) begin
                    state_d = StClear;
                    cnt_d   = 5'd0;
                end else if (cnt_q == 5'd8) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StClear: begin
                if (cnt_q == 5'd27) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            cx_q    <= 5'd0;
            cy_q    <= 5'd0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            frame_q <= frame_clk;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int x = 0; x < 28; x++) begin
                for (int y = 0; y < 28; y++) begin
                    canvas[x][y] <= 16'h0000;
                end
            end
        end else begin
            for (int x = 0; x < 28; x++) begin
                for (int y = 0; y < 28; y++) begin
                    if (wr_en && (tx == 5'(x)) && (ty == 5'(y))) begin
                        canvas[x][y] <= new_val;
                    end else if ((state_q == StClear) && (cnt_q == 5'(x))) begin
                        canvas[x][y] <= 16'h0000;
                    end
                end
            end
        end
    end

    // Read port: index = y*28 + x, out-of-range reads return zero
    logic       rd_ok;
    logic [4:0] rd_x, rd_y;

    always_comb begin
        rd_ok = (rd_addr < 10'd784);
        rd_x  = rd_ok ? 5'(rd_addr % 10'd28) : 5'd0;
        rd_y  = rd_ok ? 5'(rd_addr / 10'd28) : 5'd0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_data <= 16'h0000;
        end else begin
            rd_data <= rd_ok ? canvas[rd_x][rd_y] : 16'h0000;
        end
    end

endmodule

// File: tb/tb_canvas_painter.sv
// Directed bench for canvas_painter: table of stroke scenarios with whole-canvas
// expectations, plus hand sequences for abort, clear, async reset and the read port.
module tb_canvas_painter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  CursorX = '0;
    logic [9:0]  CursorY = '0;
    logic        Button = 1'b0;
    logic        Clear = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [15:0] canvas [0:27][0:27];
    logic [15:0] rd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    canvas_painter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .CursorX   (CursorX),
        .CursorY   (CursorY),
        .Button    (Button),
        .Clear     (Clear),
        .rd_addr   (rd_addr),
        .canvas    (canvas),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          xs;
        int          ys;
        bit          btn;
        int          nt;
        bit          wig;
        bit          paints;
        int          px;
        int          py;
        logic [15:0] c;
        logic [15:0] e;
        logic [15:0] k;
    } vec_t;

    vec_t vecs [11];

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Whole-canvas check against a stamp centred at (px,py), or all zero if !paints
    task automatic check_canvas(input string name, input bit paints, input int px, input int py,
                                input logic [15:0] c, input logic [15:0] e,
                                input logic [15:0] k);
        int bad = 0;
        int fx = 0, fy = 0;
        logic [15:0] fa = '0, fe = '0;
        checks++;
        for (int x = 0; x < 28; x++) begin
            for (int y = 0; y < 28; y++) begin
                int adx, ady;
                logic [15:0] ex;
                adx = (x > px) ? x - px : px - x;
                ady = (y > py) ? y - py : py - y;
                if (!paints)                    ex = 16'h0000;
                else if (adx == 0 && ady == 0)  ex = c;
                else if (adx + ady == 1)        ex = e;
                else if (adx <= 1 && ady <= 1)  ex = k;
                else                            ex = 16'h0000;
                if (canvas[x][y] !== ex) begin
                    if (bad == 0) begin
                        fx = x; fy = y; fa = canvas[x][y]; fe = ex;
                    end
                    bad++;
                end
            end
        end
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d cells wrong, first [%0d][%0d] got 0x%04h, expected 0x%04h",
                     name, bad, fx, fy, fa, fe);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #3 Reset = 1'b0;
    endtask

    // Issue n ticks, each followed by a bounded wait; bc counts busy cycles seen
    task automatic do_ticks(input int n, input bit wig, output int bc);
        bc = 0;
        for (int t = 0; t < n; t++) begin
            @(posedge Clk);
            #1 frame_clk = 1'b1;
            @(posedge Clk);
            #1 frame_clk = 1'b0;
            if (wig) begin
                CursorX = 10'd300;
                CursorY = 10'd300;
                Button  = 1'b0;
            end
            for (int i = 0; i < 20; i++) begin
                if (busy) bc++;
                @(posedge Clk);
                #1;
            end
        end
    endtask

    initial begin
        int bc;

        vecs[0]  = '{"single",      342, 116, 1'b1, 1, 1'b0, 1'b1, 10,  5, 16'h0400, 16'h0200, 16'h0080};
        vecs[1]  = '{"triple_sat",  342, 116, 1'b1, 3, 1'b0, 1'b1, 10,  5, 16'h07FF, 16'h0600, 16'h0180};
        vecs[2]  = '{"double_sat",  342, 116, 1'b1, 2, 1'b0, 1'b1, 10,  5, 16'h07FF, 16'h0400, 16'h0100};
        vecs[3]  = '{"cell_0_27",   202, 424, 1'b1, 1, 1'b0, 1'b1,  0, 27, 16'h0400, 16'h0200, 16'h0080};
        vecs[4]  = '{"x_left_miss", 198, 116, 1'b1, 1, 1'b0, 1'b0,  0,  0, 16'h0000, 16'h0000, 16'h0000};
        vecs[5]  = '{"no_button",   342, 116, 1'b0, 1, 1'b0, 1'b0,  0,  0, 16'h0000, 16'h0000, 16'h0000};
        vecs[6]  = '{"cell_27_27",  590, 434, 1'b1, 1, 1'b0, 1'b1, 27, 27, 16'h0400, 16'h0200, 16'h0080};
        vecs[7]  = '{"x_right_miss",591, 116, 1'b1, 1, 1'b0, 1'b0,  0,  0, 16'h0000, 16'h0000, 16'h0000};
        vecs[8]  = '{"y_top_miss",  342,  42, 1'b1, 1, 1'b0, 1'b0,  0,  0, 16'h0000, 16'h0000, 16'h0000};
        vecs[9]  = '{"origin",      199,  43, 1'b1, 1, 1'b0, 1'b1,  0,  0, 16'h0400, 16'h0200, 16'h0080};
        vecs[10] = '{"latched",     342, 116, 1'b1, 1, 1'b1, 1'b1, 10,  5, 16'h0400, 16'h0200, 16'h0080};

        do_reset();
        check_val("reset_busy", {15'd0, busy}, 16'h0000);
        check_val("reset_rd_data", rd_data, 16'h0000);
        check_canvas("reset_canvas", 1'b0, 0, 0, 16'h0, 16'h0, 16'h0);

        foreach (vecs[v]) begin
            do_reset();
            CursorX = 10'(vecs[v].xs);
            CursorY = 10'(vecs[v].ys);
            Button  = vecs[v].btn;
            do_ticks(vecs[v].nt, vecs[v].wig, bc);
            check_val({vecs[v].name, "_busy_cycles"}, 16'(bc),
                      vecs[v].paints ? 16'(9 * vecs[v].nt) : 16'd0);
            check_canvas(vecs[v].name, vecs[v].paints, vecs[v].px, vecs[v].py,
                         vecs[v].c, vecs[v].e, vecs[v].k);
        end

        // Clear raised during paint step 4
        do_reset();
        CursorX = 10'd342; CursorY = 10'd116; Button = 1'b1;
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1 Clear = 1'b1;
        check_val("abort_busy_paint", {15'd0, busy}, 16'h0001);
        @(posedge Clk);
        #1 Clear = 1'b0;
        check_val("abort_kept_write", canvas[9][5], 16'h0200);
        check_val("abort_no_step5", canvas[11][5], 16'h0000);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (i == 5) frame_clk = 1'b1;
            if (i == 6) frame_clk = 1'b0;
            @(posedge Clk);
            #1;
        end
        check_val("clear_cycles", 16'(bc), 16'd28);
        check_canvas("after_clear", 1'b0, 0, 0, 16'h0, 16'h0, 16'h0);

        // Async reset in the middle of a clear
        do_reset();
        do_ticks(1, 1'b0, bc);
        @(posedge Clk);
        #1 Clear = 1'b1;
        @(posedge Clk);
        #1 Clear = 1'b0;
        repeat (10) @(posedge Clk);
        #3;
        check_val("midclear_col10", canvas[10][5], 16'h0400);
        check_val("midclear_busy", {15'd0, busy}, 16'h0001);
        Reset = 1'b1;
        #1;
        check_val("async_reset_busy", {15'd0, busy}, 16'h0000);
        check_val("async_reset_cell", canvas[10][5], 16'h0000);
        check_canvas("async_reset_canvas", 1'b0, 0, 0, 16'h0, 16'h0, 16'h0);
        @(posedge Clk);
        #3 Reset = 1'b0;

        // Read port after painting cell (5,5)
        CursorX = 10'd272; CursorY = 10'd116; Button = 1'b1;
        do_ticks(1, 1'b0, bc);
        rd_addr = 10'd800;
        @(posedge Clk);
        #1 check_val("rd_out_of_range", rd_data, 16'h0000);
        rd_addr = 10'd145;
        #1 check_val("rd_latency", rd_data, 16'h0000);
        @(posedge Clk);
        #1 check_val("rd_145", rd_data, 16'h0400);
        rd_addr = 10'd146;
        @(posedge Clk);
        #1 check_val("rd_146", rd_data, 16'h0200);
        rd_addr = 10'd117;
        @(posedge Clk);
        #1 check_val("rd_117", rd_data, 16'h0200);
        rd_addr = 10'd116;
        @(posedge Clk);
        #1 check_val("rd_116", rd_data, 16'h0080);
        rd_addr = 10'd783;
        @(posedge Clk);
        #1 check_val("rd_783", rd_data, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
